control_sequencer: RTL and testbench

//  Hardwired control unit that drives the Datapath control inputs for one instruction.

---
 rtl/control_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_control_sequencer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// Hardwired fetch/execute control unit driving the Datapath strobes for one instruction.
// Optional build macro CTRL_SINGLE_STEP_EN adds a `step` input that gates every non-IDLE advance.
module control_sequencer #(
  parameter int unsigned NREG = 16,
  parameter int unsigned OPW  = 5
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            start,
`ifdef CTRL_SINGLE_STEP_EN
  input  logic            step,
`endif
  input  logic [31:0]     ir,
  input  logic            mem_ready,
  output logic            PCout,
  output logic            pc_increment,
  output logic            MARin,
  output logic            PCin,
  output logic            read,
  output logic            MDRin,
  output logic            MDRout,
  output logic            IRin,
  output logic            RYin,
  output logic            Zhighin,
  output logic            Zlowin,
  output logic            Zhighout,
  output logic            Zlowout,
  output logic            HIin,
  output logic            LOin,
  output logic [NREG-1:0] Rin,
  output logic [NREG-1:0] Rout,
  output logic [OPW-1:0]  op_code,
  output logic            busy,
  output logic            done,
  output logic            illegal
);

  typedef enum logic [8:0] {
    S_IDLE = 9'b000000001,
    S_T0   = 9'b000000010,
    S_T1   = 9'b000000100,
    S_T2   = 9'b000001000,
    S_T3   = 9'b000010000,
    S_T4   = 9'b000100000,
    S_T5   = 9'b001000000,
    S_T6   = 9'b010000000,
    S_DONE = 9'b100000000
  } state_e;

  typedef enum logic [1:0] {
    C_BIN,
    C_UNA,
    C_MD,
    C_ILL
  } opclass_e;

  state_e   state_q, state_d;
  logic     pcin_seen_q;
  opclass_e opclass;
  logic     adv;

  logic [4:0] op;
  logic [3:0] ra, rb, rc;
  logic       unused_ir;

  assign op        = ir[31:27];
  assign ra        = ir[26:23];
  assign rb        = ir[22:19];
  assign rc        = ir[18:15];
  assign unused_ir = ^ir[14:0];

`ifdef CTRL_SINGLE_STEP_EN
  assign adv = step;
`else
  assign adv = 1'b1;
`endif

  function automatic logic [NREG-1:0] sel(input logic [3:0] idx);
    sel = NREG'(1) << idx;
  endfunction

  always_comb begin
    unique case (op)
      5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
      5'b01000, 5'b01001, 5'b01010, 5'b01011: opclass = C_BIN;
      5'b01111, 5'b10000:                     opclass = C_MD;
      5'b10001, 5'b10010:                     opclass = C_UNA;
      default:                                opclass = C_ILL;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start) state_d = S_T0;
      S_T0:   if (adv) state_d = S_T1;
      S_T1:   if (adv && mem_ready) state_d = S_T2;
      S_T2:   if (adv) state_d = S_T3;
      S_T3:   if (adv) state_d = (opclass == C_ILL) ? S_IDLE : S_T4;
      S_T4:   if (adv) state_d = (opclass == C_UNA) ? S_DONE : S_T5;
      S_T5:   if (adv) state_d = (opclass == C_MD) ? S_T6 : S_DONE;
      S_T6:   if (adv) state_d = S_DONE;
      S_DONE: if (adv) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q     <= S_IDLE;
      pcin_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pcin_seen_q <= (state_q == S_T1) && adv;
    end
  end

  // Strobes decode state_q and ir directly: IR is only loaded at the end of T2,
  // so a registered decode would act on the previous instruction.
  always_comb begin
    PCout        = 1'b0;
    pc_increment = 1'b0;
    MARin        = 1'b0;
    PCin         = 1'b0;
    read         = 1'b0;
    MDRin        = 1'b0;
    MDRout       = 1'b0;
    IRin         = 1'b0;
    RYin         = 1'b0;
    Zhighin      = 1'b0;
    Zlowin       = 1'b0;
    Zhighout     = 1'b0;
    Zlowout      = 1'b0;
    HIin         = 1'b0;
    LOin         = 1'b0;
    Rin          = '0;
    Rout         = '0;
    op_code      = '0;
    busy         = 1'b0;
    done         = 1'b0;
    illegal      = 1'b0;
    unique case (state_q)
      S_T0: begin
        busy         = 1'b1;
        PCout        = 1'b1;
        pc_increment = 1'b1;
        MARin        = 1'b1;
        Zlowin       = 1'b1;
        Zhighin      = 1'b1;
      end
      S_T1: begin
        busy    = 1'b1;
        Zlowout = 1'b1;
        PCin    = ~pcin_seen_q;
        read    = 1'b1;
        MDRin   = 1'b1;
      end
      S_T2: begin
        busy   = 1'b1;
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      S_T3: begin
        busy = 1'b1;
        unique case (opclass)
          C_BIN: begin Rout = sel(rb); RYin = 1'b1; end
          C_MD:  begin Rout = sel(ra); RYin = 1'b1; end
          C_UNA: begin
            Rout    = sel(rb);
            op_code = OPW'(op);
            Zlowin  = 1'b1;
            Zhighin = 1'b1;
          end
          default: illegal = 1'b1;
        endcase
      end
      S_T4: begin
        busy = 1'b1;
        if (opclass == C_UNA) begin
          Zlowout = 1'b1;
          Rin     = sel(ra);
        end else begin
          Rout    = (opclass == C_MD) ? sel(rb) : sel(rc);
          op_code = OPW'(op);
          Zlowin  = 1'b1;
          Zhighin = 1'b1;
        end
      end
      S_T5: begin
        busy    = 1'b1;
        Zlowout = 1'b1;
        if (opclass == C_MD) LOin = 1'b1;
        else                 Rin  = sel(ra);
      end
      S_T6: begin
        busy     = 1'b1;
        Zhighout = 1'b1;
        HIin     = 1'b1;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: directed scenarios plus randomized
// instructions compared cycle by cycle against a per-instruction expected strobe schedule.
module tb_control_sequencer;

  typedef struct packed {
    logic        PCout, pc_increment, MARin, PCin, read, MDRin, MDRout, IRin, RYin;
    logic        Zhighin, Zlowin, Zhighout, Zlowout, HIin, LOin, busy, done, illegal;
    logic [15:0] Rin, Rout;
    logic [4:0]  op_code;
  } obs_t;

  logic        clk = 1'b0;
  logic        clr, start, mem_ready;
  logic [31:0] ir;
  logic        PCout, pc_increment, MARin, PCin, read, MDRin, MDRout, IRin, RYin;
  logic        Zhighin, Zlowin, Zhighout, Zlowout, HIin, LOin, busy, done, illegal;
  logic [15:0] Rin, Rout;
  logic [4:0]  op_code;

  int checks   = 0;
  int failures = 0;
  obs_t exp_q[$];

  logic [4:0] bin_ops [9] = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11};
  logic [4:0] md_ops  [2] = '{5'd15, 5'd16};
  logic [4:0] una_ops [2] = '{5'd17, 5'd18};
  logic [4:0] legal   [13] = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11,
                               5'd15, 5'd16, 5'd17, 5'd18};

  always #5 clk = ~clk;

  control_sequencer #(.NREG(16), .OPW(5)) dut (
    .clk(clk), .clr(clr), .start(start), .ir(ir), .mem_ready(mem_ready),
    .PCout(PCout), .pc_increment(pc_increment), .MARin(MARin), .PCin(PCin),
    .read(read), .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .RYin(RYin),
    .Zhighin(Zhighin), .Zlowin(Zlowin), .Zhighout(Zhighout), .Zlowout(Zlowout),
    .HIin(HIin), .LOin(LOin), .Rin(Rin), .Rout(Rout), .op_code(op_code),
    .busy(busy), .done(done), .illegal(illegal)
  );

  function automatic obs_t sample();
    obs_t o;
    o = '0;
    o.PCout = PCout; o.pc_increment = pc_increment; o.MARin = MARin; o.PCin = PCin;
    o.read = read; o.MDRin = MDRin; o.MDRout = MDRout; o.IRin = IRin; o.RYin = RYin;
    o.Zhighin = Zhighin; o.Zlowin = Zlowin; o.Zhighout = Zhighout; o.Zlowout = Zlowout;
    o.HIin = HIin; o.LOin = LOin; o.busy = busy; o.done = done; o.illegal = illegal;
    o.Rin = Rin; o.Rout = Rout; o.op_code = op_code;
    return o;
  endfunction

  // 0 = binary, 1 = unary, 2 = mul/div, 3 = undefined
  function automatic int kind_of(input logic [4:0] op);
    foreach (bin_ops[i]) if (bin_ops[i] == op) return 0;
    foreach (una_ops[i]) if (una_ops[i] == op) return 1;
    foreach (md_ops[i])  if (md_ops[i]  == op) return 2;
    return 3;
  endfunction

  task automatic check(input string tag, input obs_t e);
    obs_t o;
    int   drv;
    o = sample();
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
    drv = $countones(Rout) + int'(PCout) + int'(MDRout) + int'(Zlowout) + int'(Zhighout);
    checks++;
    assert (drv <= 1) else begin
      failures++;
      $error("FAIL %s bus_drivers observed=%0d expected<=1", tag, drv);
    end
    checks++;
    assert ($onehot0(Rin)) else begin
      failures++;
      $error("FAIL %s rin_onehot observed=%h expected=at most one bit", tag, Rin);
    end
  endtask

  task automatic build(input logic [31:0] iv, input int stall);
    obs_t       e;
    logic [4:0] op;
    logic [15:0] ra, rb, rc;
    op = iv[31:27];
    ra = 16'd1 << iv[26:23];
    rb = 16'd1 << iv[22:19];
    rc = 16'd1 << iv[18:15];
    exp_q.delete();
    e = '0; e.busy = 1; e.PCout = 1; e.pc_increment = 1; e.MARin = 1; e.Zlowin = 1; e.Zhighin = 1;
    exp_q.push_back(e);
    for (int s = 0; s <= stall; s++) begin
      e = '0; e.busy = 1; e.Zlowout = 1; e.read = 1; e.MDRin = 1; e.PCin = (s == 0);
      exp_q.push_back(e);
    end
    e = '0; e.busy = 1; e.MDRout = 1; e.IRin = 1;
    exp_q.push_back(e);
    case (kind_of(op))
      0: begin
        e = '0; e.busy = 1; e.Rout = rb; e.RYin = 1; exp_q.push_back(e);
        e = '0; e.busy = 1; e.Rout = rc; e.op_code = op; e.Zlowin = 1; e.Zhighin = 1; exp_q.push_back(e);
        e = '0; e.busy = 1; e.Zlowout = 1; e.Rin = ra; exp_q.push_back(e);
      end
      1: begin
        e = '0; e.busy = 1; e.Rout = rb; e.op_code = op; e.Zlowin = 1; e.Zhighin = 1; exp_q.push_back(e);
        e = '0; e.busy = 1; e.Zlowout = 1; e.Rin = ra; exp_q.push_back(e);
      end
      2: begin
        e = '0; e.busy = 1; e.Rout = ra; e.RYin = 1; exp_q.push_back(e);
        e = '0; e.busy = 1; e.Rout = rb; e.op_code = op; e.Zlowin = 1; e.Zhighin = 1; exp_q.push_back(e);
        e = '0; e.busy = 1; e.Zlowout = 1; e.LOin = 1; exp_q.push_back(e);
        e = '0; e.busy = 1; e.Zhighout = 1; e.HIin = 1; exp_q.push_back(e);
      end
      default: begin
        e = '0; e.busy = 1; e.illegal = 1; exp_q.push_back(e);
      end
    endcase
    if (kind_of(op) != 3) begin
      e = '0; e.done = 1; exp_q.push_back(e);
    end
    exp_q.push_back('0);
  endtask

  // Runs one instruction; ir carries junk until T3 so fetch must not depend on it.
  task automatic run(input string name, input logic [31:0] iv, input int stall,
                     input bit hold, input int clr_at, input bit started);
    int fetch_len;
    int idx;
    bit last;
    build(iv, stall);
    fetch_len = 3 + stall;
    if (!started) begin
      @(negedge clk);
      clr = 0; start = 1; ir = $urandom; mem_ready = 1'($urandom);
      #1 check($sformatf("%s idle", name), '0);
    end
    for (int k = 1; k <= exp_q.size(); k++) begin
      @(negedge clk);
      idx  = k - 1;
      last = (k == exp_q.size());
      ir   = (idx >= fetch_len) ? iv : $urandom;
      if (idx >= 1 && idx <= stall) mem_ready = 1'b0;
      else if (idx == stall + 1)    mem_ready = 1'b1;
      else                          mem_ready = 1'($urandom);
      start = hold ? 1'b1 : (last ? 1'b0 : 1'($urandom));
      #1 check($sformatf("%s c%0d", name, k), exp_q[idx]);
      if (idx == clr_at) begin
        clr = 1;
        @(negedge clk);
        clr = 0; start = 0;
        #1 check($sformatf("%s after_clr", name), '0);
        return;
      end
    end
  endtask

  initial begin
    logic [31:0] iv;
    logic [4:0]  op;
    clr = 1; start = 0; mem_ready = 0; ir = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1 check("reset", '0);
    clr = 0;

    run("shl",     32'h5A1B8000, 0, 0, -1, 0);
    run("mul",     32'h79280000, 0, 0, -1, 0);
    run("stall3",  {5'b00011, 4'd1, 4'd2, 4'd3, 15'd0}, 3, 0, -1, 0);
    run("illegal", 32'hF8000000, 0, 0, -1, 0);
    run("clr_t4",  {5'b00011, 4'd9, 4'd10, 4'd11, 15'd0}, 0, 0, 4, 0);
    run("refetch", {5'b00011, 4'd9, 4'd10, 4'd11, 15'd0}, 1, 0, -1, 0);
    run("hold",    {5'b10010, 4'd6, 4'd14, 4'd0, 15'd0}, 0, 1, -1, 0);
    run("chained", {5'b00100, 4'd15, 4'd0, 4'd8, 15'd0}, 2, 0, -1, 1);

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0) op = 5'($urandom_range(0, 31));
      else                           op = legal[$urandom_range(0, 12)];
      iv = {op, 4'($urandom), 4'($urandom), 4'($urandom), 15'($urandom)};
      run($sformatf("rnd%0d", n), iv, int'($urandom_range(0, 3)), 0, -1, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
